// File: rtl/step_pkg.sv
// Shared definitions for the pedometer execute stage: opcodes, instruction
// field positions and the execute FSM encoding.
package step_pkg;

    localparam logic [3:0] OP_COUNT = 4'b1100;
    localparam logic [3:0] OP_CLRW  = 4'b0010;
    localparam logic [3:0] OP_WR2   = 4'b1010;
    localparam logic [3:0] OP_WR1   = 4'b0110;

    localparam int OP_LSB    = 0;
    localparam int OP_MSB    = 3;
    localparam int A_LSB     = 4;
    localparam int A_MSB     = 11;
    localparam int B_LSB     = 12;
    localparam int B_MSB     = 19;
    localparam int ADDR1_LSB = 4;
    localparam int ADDR1_MSB = 6;
    localparam int DATA1_LSB = 7;
    localparam int DATA1_MSB = 14;
    localparam int ADDR2_LSB = 15;
    localparam int ADDR2_MSB = 17;
    localparam int DATA2_LSB = 18;
    localparam int DATA2_MSB = 25;

    localparam logic [2:0] SPARE_REG = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL_A = 2'd1,
        S_MUL_B = 2'd2,
        S_CMP   = 2'd3
    } state_t;

endpackage

// File: rtl/step_exec_unit_weight_regfile.sv
// 8x8-bit weight registers: two write ports (port 2 wins on collision),
// synchronous clear, three combinational read taps.
module weight_regfile #(
    parameter int RA_IDX = 0,
    parameter int RB_IDX = 1,
    parameter int RT_IDX = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       we,
    input  logic [2:0] addr1,
    input  logic [7:0] data1,
    input  logic [2:0] addr2,
    input  logic [7:0] data2,
    output logic [7:0] w_a,
    output logic [7:0] w_b,
    output logic [7:0] w_th
);

    logic [7:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (we) begin
            // Later assignment takes effect, so port 2 wins a collision.
            regs[addr1] <= data1;
            regs[addr2] <= data2;
        end
    end

    assign w_a  = regs[RA_IDX];
    assign w_b  = regs[RB_IDX];
    assign w_th = regs[RT_IDX];

endmodule

// File: rtl/step_exec_unit.sv
// Execute stage: decodes pedometer instructions, owns the weight file and
// scores COUNT operands over two cycles with one shared multiplier.
module step_exec_unit
    import step_pkg::*;
#(
    parameter int COUNT_W  = 16,
    parameter int W_A_IDX  = 0,
    parameter int W_B_IDX  = 1,
    parameter int W_TH_IDX = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    output logic               instr_ready,
    output logic               done,
    output logic [COUNT_W-1:0] step_count,
    output logic               step_detected,
    output logic               illegal_op
);

    // Handshake: an instruction transfers on a clk edge with
    // instr_valid=1 and instr_ready=1; fetch holds the word until then.

    state_t      state;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [16:0] acc;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [7:0]  w_th;
    logic [7:0]  mul_x;
    logic [7:0]  mul_w;
    logic [15:0] product;
    logic        above;
    logic        accept;
    logic [3:0]  op;
    logic        unused_instr;

    assign op           = instruction[OP_MSB:OP_LSB];
    assign accept       = instr_valid && instr_ready;
    assign unused_instr = ^instruction[31:26];

    weight_regfile #(
        .RA_IDX(W_A_IDX),
        .RB_IDX(W_B_IDX),
        .RT_IDX(W_TH_IDX)
    ) u_regs (
        .clk  (clk),
        .reset(reset),
        .clr  (accept && (op == OP_CLRW)),
        .we   (accept && ((op == OP_WR2) || (op == OP_WR1))),
        .addr1(instruction[ADDR1_MSB:ADDR1_LSB]),
        .data1(instruction[DATA1_MSB:DATA1_LSB]),
        .addr2(instruction[ADDR2_MSB:ADDR2_LSB]),
        .data2(instruction[DATA2_MSB:DATA2_LSB]),
        .w_a  (w_a),
        .w_b  (w_b),
        .w_th (w_th)
    );

    // One multiplier serves both MUL_A and MUL_B.
    assign mul_x   = (state == S_MUL_A) ? op_a : op_b;
    assign mul_w   = (state == S_MUL_A) ? w_a : w_b;
    assign product = mul_x * mul_w;
    assign above   = (acc > {1'b0, w_th, 8'h00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            instr_ready   <= 1'b1;
            done          <= 1'b0;
            illegal_op    <= 1'b0;
            step_count    <= '0;
            step_detected <= 1'b0;
            acc           <= '0;
            op_a          <= '0;
            op_b          <= '0;
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_COUNT: begin
                                op_a        <= instruction[A_MSB:A_LSB];
                                op_b        <= instruction[B_MSB:B_LSB];
                                state       <= S_MUL_A;
                                instr_ready <= 1'b0;
                            end
                            OP_CLRW, OP_WR2, OP_WR1: done <= 1'b1;
                            default: illegal_op <= 1'b1;
                        endcase
                    end
                end
                S_MUL_A: begin
                    acc   <= {1'b0, product};
                    state <= S_MUL_B;
                end
                S_MUL_B: begin
                    acc   <= acc + {1'b0, product};
                    state <= S_CMP;
                end
                S_CMP: begin
                    // Count only rising crossings; hold at all-ones.
                    if (above && !step_detected && (step_count != '1))
                        step_count <= step_count + 1'b1;
                    step_detected <= above;
                    done          <= 1'b1;
                    state         <= S_IDLE;
                    instr_ready   <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_exec_unit.sv
// Bench for step_exec_unit: reference model feeds an expected-result queue
// that is checked whenever the unit signals done or illegal_op.
module tb_step_exec_unit;

    localparam int CW = 4;
    localparam int EW = CW + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic [31:0]   instruction = '0;
    logic          instr_ready;
    logic          done;
    logic [CW-1:0] step_count;
    logic          step_detected;
    logic          illegal_op;

    int total = 0;
    int bad = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    mw[8];
    logic [CW-1:0] m_cnt;
    logic          m_det;

    step_exec_unit #(.COUNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .instr_ready  (instr_ready),
        .done         (done),
        .step_count   (step_count),
        .step_detected(step_detected),
        .illegal_op   (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_count(input logic [7:0] a, input logic [7:0] b);
        return {12'b0, b, a, 4'b1100};
    endfunction

    function automatic logic [31:0] mk_wr(input logic [3:0] op, input logic [2:0] a1,
                                          input logic [7:0] d1, input logic [2:0] a2,
                                          input logic [7:0] d2);
        return {6'b0, d2, a2, d1, a1, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mw[i] = 8'h00;
        m_cnt = '0;
        m_det = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] w);
        int score;
        logic ab;
        case (w[3:0])
            4'b1100: begin
                score = int'(w[11:4]) * int'(mw[0]) + int'(w[19:12]) * int'(mw[1]);
                ab = (score > int'(mw[2]) * 256);
                if (ab && !m_det && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
                m_det = ab;
                exp_q.push_back({1'b0, m_det, m_cnt});
            end
            4'b0010: begin
                for (int i = 0; i < 8; i++) mw[i] = 8'h00;
                exp_q.push_back({1'b0, m_det, m_cnt});
            end
            4'b1010, 4'b0110: begin
                mw[w[6:4]]   = w[14:7];
                mw[w[17:15]] = w[25:18];
                exp_q.push_back({1'b0, m_det, m_cnt});
            end
            default: exp_q.push_back({1'b1, m_det, m_cnt});
        endcase
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!reset && (done || illegal_op)) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected got={ill=%b det=%b cnt=%0d} need=no event",
                         illegal_op, step_detected, step_count);
                bad++;
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({illegal_op, step_detected, step_count} !== e) begin
                    $display("FAIL sb_result got={ill=%b det=%b cnt=%0d} need={ill=%b det=%b cnt=%0d}",
                             illegal_op, step_detected, step_count, e[EW-1], e[EW-2], e[CW-1:0]);
                    bad++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instruction = w;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout ready=%b need=1", instr_ready);
        end
        @(posedge clk);
        model_accept(w);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout done=%b need=1", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        total++;
        if ({instr_ready, done, step_count, step_detected, illegal_op} !== {1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs got=rdy%b done%b cnt%0d det%b ill%b need=rdy1 done0 cnt0 det0 ill0",
                     instr_ready, done, step_count, step_detected, illegal_op);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dut.u_regs.regs[i] !== 8'h00) begin
                $display("FAIL reset_weight%0d got=%h need=00", i, dut.u_regs.regs[i]);
                bad++;
            end
        end
    endtask

    task automatic test_writes();
        send(mk_wr(4'b1010, 3'd7, 8'h99, 3'd3, 8'h00));
        send(mk_wr(4'b1010, 3'd0, 8'd2, 3'd1, 8'd3));
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b1) begin
            $display("FAIL wr2_b2b got=rdy%b done%b need=rdy1 done1", instr_ready, done);
            bad++;
        end
        send(mk_wr(4'b0110, 3'd2, 8'd1, 3'd7, 8'd0));
        total++;
        if (instr_ready !== 1'b1 || done !== 1'b1) begin
            $display("FAIL wr1_done got=rdy%b done%b need=rdy1 done1", instr_ready, done);
            bad++;
        end
        @(negedge clk);
        total++;
        if ({dut.u_regs.regs[0], dut.u_regs.regs[1], dut.u_regs.regs[2], dut.u_regs.regs[7]} !== 32'h02030100) begin
            $display("FAIL wr_weights got=%h %h %h %h need=02 03 01 00", dut.u_regs.regs[0],
                     dut.u_regs.regs[1], dut.u_regs.regs[2], dut.u_regs.regs[7]);
            bad++;
        end
        total++;
        if (done !== 1'b0) begin
            $display("FAIL wr_done_pulse got=%b need=0", done);
            bad++;
        end
    endtask

    task automatic test_count();
        int n;
        for (int k = 0; k < 2; k++) begin
            send(mk_count(8'd100, 8'd30));
            total++;
            if (instr_ready !== 1'b0) begin
                $display("FAIL count_busy got=%b need=0", instr_ready);
                bad++;
            end
            n = 1;
            while (!done && n < 10) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n != 4) begin
                $display("FAIL count_latency got=%0d need=4", n);
                bad++;
            end
            total++;
            if (step_count !== 4'd1 || step_detected !== 1'b1) begin
                $display("FAIL count_high got=cnt%0d det%b need=cnt1 det1", step_count, step_detected);
                bad++;
            end
        end
    endtask

    task automatic test_low_then_high();
        send(mk_count(8'd10, 8'd10));
        wait_done();
        total++;
        if (step_detected !== 1'b0 || step_count !== 4'd1) begin
            $display("FAIL count_low got=cnt%0d det%b need=cnt1 det0", step_count, step_detected);
            bad++;
        end
        send(mk_count(8'd100, 8'd30));
        wait_done();
        total++;
        if (step_count !== 4'd2) begin
            $display("FAIL count_rise got=%0d need=2", step_count);
            bad++;
        end
    endtask

    task automatic test_collision_illegal_clrw();
        send(mk_wr(4'b1010, 3'd5, 8'hAA, 3'd5, 8'h55));
        @(negedge clk);
        total++;
        if (dut.u_regs.regs[5] !== 8'h55) begin
            $display("FAIL collision got=%h need=55", dut.u_regs.regs[5]);
            bad++;
        end
        send({28'h0001234, 4'b1111});
        total++;
        if (illegal_op !== 1'b1) begin
            $display("FAIL illegal_pulse got=%b need=1", illegal_op);
            bad++;
        end
        @(negedge clk);
        total++;
        if (illegal_op !== 1'b0) begin
            $display("FAIL illegal_clear got=%b need=0", illegal_op);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dut.u_regs.regs[i] !== mw[i]) begin
                $display("FAIL illegal_weight%0d got=%h need=%h", i, dut.u_regs.regs[i], mw[i]);
                bad++;
            end
        end
        send(mk_wr(4'b0010, 3'd0, 8'd0, 3'd0, 8'd0));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dut.u_regs.regs[i] !== 8'h00) begin
                $display("FAIL clrw_weight%0d got=%h need=00", i, dut.u_regs.regs[i]);
                bad++;
            end
        end
        total++;
        if (step_count !== 4'd2) begin
            $display("FAIL clrw_count got=%0d need=2", step_count);
            bad++;
        end
    endtask

    task automatic test_saturate();
        send(mk_wr(4'b1010, 3'd0, 8'd2, 3'd1, 8'd3));
        send(mk_wr(4'b0110, 3'd2, 8'd1, 3'd7, 8'd0));
        for (int k = 0; k < 40 && m_cnt != {CW{1'b1}}; k++) begin
            send(mk_count(8'd10, 8'd10));
            wait_done();
            send(mk_count(8'd100, 8'd30));
            wait_done();
        end
        total++;
        if (step_count !== {CW{1'b1}}) begin
            $display("FAIL sat_reach got=%0d need=%0d", step_count, {CW{1'b1}});
            bad++;
        end
        send(mk_count(8'd10, 8'd10));
        wait_done();
        send(mk_count(8'd255, 8'd255));
        wait_done();
        total++;
        if (step_count !== {CW{1'b1}} || step_detected !== 1'b1) begin
            $display("FAIL sat_hold got=cnt%0d det%b need=cnt%0d det1", step_count, step_detected, {CW{1'b1}});
            bad++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic seen;
        seen = 1'b0;
        send(mk_count(8'd10, 8'd10));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        total++;
        if ({instr_ready, done, step_count, step_detected} !== {1'b1, 1'b0, {CW{1'b0}}, 1'b0}) begin
            $display("FAIL midrst_outputs got=rdy%b done%b cnt%0d det%b need=rdy1 done0 cnt0 det0",
                     instr_ready, done, step_count, step_detected);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dut.u_regs.regs[i] !== 8'h00) begin
                $display("FAIL midrst_weight%0d got=%h need=00", i, dut.u_regs.regs[i]);
                bad++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            $display("FAIL midrst_no_done got=%b need=0", seen);
            bad++;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_writes();
        test_count();
        test_low_then_high();
        test_collision_illegal_clrw();
        test_saturate();
        test_reset_mid_count();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_leftover got=%0d need=0", exp_q.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
